// File: rtl/pcm_bram_writer.sv
// PCM frame capture into a simple dual-port block RAM, with a registered
// random-access read port for the equalizer datapath.
module pcm_bram_writer #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      frame_len,
  input  logic [BIT_DEPTH-1:0] data,
  input  logic                 data_valid,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      count,
  output logic                 overrun,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BIT_DEPTH-1:0] rd_data,
  output logic                 rd_valid
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [BIT_DEPTH-1:0]  rd_data_q;
  logic                  rd_valid_q;
  logic [ADDR_W:0]       len_eff;
  logic                  wr_en;
  logic                  last_wr;

  logic [BIT_DEPTH-1:0]  mem [DEPTH];

  // A length of zero or beyond the buffer means a full buffer.
  assign len_eff = ((frame_len == '0) || (frame_len > DEPTH_L)) ? DEPTH_L : frame_len;
  assign wr_en   = (state_q == CAPTURE) && data_valid;
  assign last_wr = wr_en && ((count_q + CNT_ONE) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = CAPTURE;
      CAPTURE: if (last_wr) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len_eff;
          wr_ptr_d  = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end else if (data_valid) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (data_valid) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
          done_d   = last_wr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      len_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data;
  end

  // Non-blocking read of the array gives read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem[rd_addr];
    end
  end

  assign busy     = (state_q == CAPTURE);
  assign done     = done_q;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pcm_bram_writer.sv
// Directed bench for pcm_bram_writer with a 16-sample buffer.
module tb_pcm_bram_writer;

  localparam int unsigned BD = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   frame_len;
  logic [BD-1:0] data;
  logic          data_valid;
  logic          busy, done, overrun, rd_en, rd_valid;
  logic [AW:0]   count;
  logic [AW-1:0] rd_addr;
  logic [BD-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  pcm_bram_writer #(.BIT_DEPTH(BD), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .data(data), .data_valid(data_valid), .busy(busy), .done(done),
    .count(count), .overrun(overrun), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [BD-1:0] exp);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    chk("rd_data", 32'(rd_data), 32'(exp));
    chk("rd_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
  endtask

  task automatic put(input logic [BD-1:0] d);
    data = d;
    data_valid = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; frame_len = '0; data = 8'h55; data_valid = 1'b1;
    rd_en = 1'b0; rd_addr = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle_overrun", 32'(overrun), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    data_valid = 1'b0;

    // Full frame of four samples
    frame_len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("f4_busy", 32'(busy), 32'd1);
    chk("f4_count0", 32'(count), 32'd0);
    chk("f4_ovr_clr", 32'(overrun), 32'd0);
    put(8'h05); chk("f4_count1", 32'(count), 32'd1);
    put(8'hFD); chk("f4_count2", 32'(count), 32'd2);
    put(8'h7F); chk("f4_count3", 32'(count), 32'd3);
    chk("f4_no_done", 32'(done), 32'd0);
    put(8'h80);
    chk("f4_done", 32'(done), 32'd1);
    chk("f4_busy_off", 32'(busy), 32'd0);
    chk("f4_count4", 32'(count), 32'd4);
    data = 8'h33;
    step();
    data_valid = 1'b0;
    chk("f4_done_off", 32'(done), 32'd0);
    chk("f4_ovr_after", 32'(overrun), 32'd1);
    chk("f4_count_hold", 32'(count), 32'd4);
    rd(4'd0, 8'h05);
    rd(4'd1, 8'hFD);
    rd(4'd2, 8'h7F);
    rd(4'd3, 8'h80);
    step();
    chk("rd_valid_low", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'h80);

    // Length 0 means the whole buffer; input gapped every other cycle
    frame_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      put(8'(i * 3 + 1));
      chk("gap_count", 32'(count), 32'(i + 1));
      chk("gap_done", 32'(done), 32'(i == 15));
      chk("gap_busy", 32'(busy), 32'(i != 15));
      data_valid = 1'b0;
      step();
      chk("gap_done_idle", 32'(done), 32'd0);
      chk("gap_busy_idle", 32'(busy), 32'(i != 15));
    end
    chk("gap_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'(i * 3 + 1));

    // Start mid-capture is ignored; start in the done cycle re-arms
    frame_len = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    put(8'd10); chk("sh_count1", 32'(count), 32'd1);
    start = 1'b1; frame_len = 5'd1;
    put(8'd11);
    start = 1'b0;
    chk("sh_count2", 32'(count), 32'd2);
    chk("sh_busy", 32'(busy), 32'd1);
    chk("sh_no_done", 32'(done), 32'd0);
    put(8'd7);
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_count3", 32'(count), 32'd3);
    start = 1'b1; frame_len = 5'd3; data = 8'd99;
    step();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_count0", 32'(count), 32'd0);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    chk("b2b_done_off", 32'(done), 32'd0);
    put(8'd20);
    put(8'd21);
    rd_en = 1'b1; rd_addr = 4'd2;
    put(8'd9);
    rd_en = 1'b0; data_valid = 1'b0;
    chk("coll_old", 32'(rd_data), 32'd7);
    chk("coll_done", 32'(done), 32'd1);
    rd(4'd2, 8'd9);
    rd(4'd0, 8'd20);

    // Reset mid-capture
    frame_len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    put(8'h40);
    put(8'h41);
    data_valid = 1'b0;
    chk("mid_count2", 32'(count), 32'd2);
    rst = 1'b1;
    #2;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_done_after", 32'(done), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    frame_len = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    put(8'h50);
    put(8'h51);
    data_valid = 1'b0;
    chk("new_done", 32'(done), 32'd1);
    chk("new_count", 32'(count), 32'd2);
    rd(4'd0, 8'h50);
    rd(4'd1, 8'h51);
    rd(4'd2, 8'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_bram_writer.md
# pcm_bram_writer

Sink for the PCM sample stream (`data`/`data_valid`) on the PCM-into-BRAM path. Captures one frame of signed PCM samples of programmable length into an internal simple dual-port block RAM. Exposes a registered random-access read port so the equalizer datapath can fetch samples by address. Reports progress, completion and samples dropped outside a capture window.

## Interface
- `BIT_DEPTH`, 8, PCM sample width in bits.
- `DEPTH`, 1024, buffer size in samples; a power of two, ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`, address width.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle arm pulse; begins a capture.
- `frame_len`  in  ADDR_W+1  samples to capture; sampled on `start`. A value of 0 or > DEPTH means DEPTH.
- `data`  in  BIT_DEPTH  signed PCM sample.
- `data_valid`  in  1  `data` is valid this cycle.
- `busy`  out  1  capture in progress.
- `done`  out  1  one-cycle pulse after the last sample of the frame is written.
- `count`  out  ADDR_W+1  samples written in the current or last frame.
- `overrun`  out  1  sticky; a valid sample arrived while not capturing.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  BIT_DEPTH  read data.
- `rd_valid`  out  1  `rd_data` was updated by the previous cycle's `rd_en`.

## Operation
- **Reset values:** state IDLE; `busy`=0, `done`=0, `count`=0, `overrun`=0, `rd_data`=0, `rd_valid`=0, write pointer 0, latched length 0. Memory contents are not reset.
- **FSM states:** IDLE, CAPTURE.
- **IDLE, `start`=1:**
  - latch the effective length L from `frame_len`, clamped as above;
  - clear the write pointer, `count` and `overrun`;
  - go to CAPTURE.
  - `data_valid` in the `start` cycle is ignored: not written, not flagged.
- **IDLE, `start`=0, `data_valid`=1:** sample dropped; `overrun` set.
- **CAPTURE, `data_valid`=1:**
  - write `data` to mem[wr_ptr];
  - wr_ptr += 1; `count` += 1.
  - If this write is sample L-1, go to IDLE and assert `done` next cycle.
- **CAPTURE, `start`:** ignored; no restart and no length change.
- **CAPTURE, `data_valid`=0:** hold; no timeout.
- **Addressing:** the write pointer never wraps within a frame, since L ≤ DEPTH. Each frame restarts at address 0.
- **`count`:** holds its final value (L) in IDLE until the next accepted `start`.
- **Read port:**
  - Operates in every state, independent of capture.
  - `rd_en`=1 registers mem[`rd_addr`] into `rd_data`.
  - `rd_data` holds its value while `rd_en`=0.
  - Reading an address not yet written this frame returns the stale contents.
- **Read/write collision** (same cycle, same address): read-before-write; `rd_data` gets the old word.
- **Arithmetic:** no arithmetic on sample data; `data` is stored bit-exact as two's-complement.
- **Reset mid-capture:** immediate return to IDLE with all outputs at their reset values; no `done`. Partially written memory is left as-is.

## Timing
- `start` at cycle t: `busy`=1 from t+1. The earliest captured sample is the one with `data_valid` at t+1.
- Sample k (0-based) valid at cycle c: in memory after the edge ending c; `count`=k+1 from c+1.
- Last sample (k=L-1) at cycle c:
  - `busy`=0 and `done`=1 during c+1;
  - `done`=0 at c+2;
  - a `data_valid` at c+1 sets `overrun`.
- Minimum frame duration is L cycles when `data_valid` is held high. `start` at the `done` cycle is accepted (back-to-back frames).
- **Read latency:** 1 cycle. `rd_en` at c gives `rd_data`/`rd_valid`=1 at c+1; `rd_valid`=0 at c+1 if `rd_en`=0 at c.
- A sample written at cycle c is readable by `rd_en` at c+1, giving data at c+2.

## Test plan
- **Reset behaviour:** reset with `data_valid`=1 and `start` held → all outputs 0. After `rst` falls, `data_valid`=1 sets `overrun`=1 on the next edge.
- **Full frame:** `frame_len`=4, `start`, then samples 5, -3, 127, -128 on consecutive cycles → `done` pulses 1 cycle after -128. `count`=4; reads of addr 0..3 return 5, -3, 127, -128 with 1-cycle latency.
- **Gapped input and boundaries:** `frame_len`=0 with DEPTH=16 and `data_valid` toggling 1/0 → exactly 16 writes at addr 0..15. `done` pulses once, after the 16th valid sample; `busy` is high throughout.
- **Start handling:** `start` in CAPTURE mid-frame is ignored (`count` continues). `start` in the `done` cycle begins a new frame: `count`=0 and `overrun` cleared next cycle.
- **Collision:** write value 9 to addr 2 while `rd_en` at addr 2 (old value 7) → `rd_data`=7. A read next cycle returns 9.
- **Reset mid-capture:** `rst` after 2 of 4 samples → `busy`=0, `count`=0, no `done`. A new frame then rewrites from addr 0.
